pow_seq: RTL and testbench
==========================

# pow_seq

Parametrised sequential unsigned exponentiation unit: computes `inx ** inn` truncated to W bits by square-and-multiply, plus an exact overflow flag. It is the next generation of the lab exponentiation block: generic operand/exponent widths, an area-cheap multi-cycle shift-add multiplier instead of a combinational one, a one-cycle `done` strobe, `abort`, and overflow detection. It is a standalone datapath driven by a simple start/ready handshake.

## Interface
- `W`, 16: operand and result width, ≥ 2.
- `NW`, 8: exponent width, ≥ 1.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `abort`  in  1  cancels an operation in progress; ignored when idle.
- `inx`  in  W  base, unsigned; sampled with `start`.
- `inn`  in  NW  exponent, unsigned; sampled with `start`.
- `ready`  out  1  high in IDLE.
- `done`  out  1  one-cycle strobe: `out`/`ovf` just updated.
- `out`  out  W  `inx**inn mod 2^W`; held until the next completion.
- `ovf`  out  1  1 iff the true result ≥ 2^W; held with `out`.

## Operation
- Reset: state IDLE; `ready`=1, `done`=0, `out`=0, `ovf`=0. Internal a, x, n, and flags are cleared.
- States: IDLE, CHECK, MUL.
- IDLE with `start`: load a←1, x←`inx`, n←`inn`, a_big←0, x_big←0; go to CHECK. `ready` drops next cycle. `start` while busy is ignored.
- CHECK:
  - If n==0: `out`←a, `ovf`←a_big, `done`←1, go to IDLE.
  - Else: launch the multiplier (n even: x·x; n odd: a·x), go to MUL.
- MUL: wait for multiplier `mdone`, then commit the 2W-bit product p, with hi = p[2W-1:W] and lo = p[W-1:0], and go to CHECK:
  - Even n: x←lo; x_big←x_big | (hi≠0); n←n>>1.
  - Odd n: a←lo; a_big←a_big | x_big | (hi≠0); n←n−1.
- Overflow flag is exact:
  - When `inx`≠0, both true operands are ≥1, so a product is ≥ 2^W iff either operand's big flag is set or hi≠0.
  - When `inx`=0, every product is 0, and neither flag can set.
- `abort` in CHECK or MUL: next state IDLE. No `done` strobe; `out`/`ovf` unchanged; the multiplier is cleared.
- `rst` mid-operation: same as power-on reset. `rst` has priority over `abort`, and `abort` over all else.
- `done` is high exactly one cycle, only on completion.

## Timing
- Multiplier latency: operands are latched on the launching edge. `mdone` is high in the W-th cycle after it, and the product is committed on that edge. Each step therefore costs W+1 edges (1 CHECK + W MUL).
- Call the edge that samples `start` E0, and let s be the number of steps. The steps are one squaring per halving plus one multiply per odd n value encountered.
- `done` is asserted (and `ready` returns high) in the cycle after edge E0 + s·(W+1) + 1.
- n=0 gives s=0: `done` in the cycle after E0+1.
- A new `start` is accepted in the same cycle `done`/`ready` are high.

## Structure
- `pow_pkg`:
  - state enum `pow_state_t` {IDLE, CHECK, MUL};
  - default width constants `POW_W_DEF`=16 and `POW_NW_DEF`=8.
- Sub-module `mult_seq #(W)`: radix-2 shift-add W×W→2W multiplier with ports `clk`, `rst`, `clr`, `go`, `a`, `b`, `p`, `mdone`.
  - It takes exactly W cycles.
  - `clr` is driven by abort.
- `pow_seq` holds the FSM, the a/x/n registers, the big flags, and operand selection.

## Test plan
- W=16, `inx`=3, `inn`=5 → s=4; `done` after E0+69; `out`=243, `ovf`=0. `ready` low throughout, `done` high exactly one cycle.
- `inx`=3, `inn`=11 → `out`=46075 (177147 mod 65536), `ovf`=1. Also `inx`=2: `inn`=15 → 32768, `ovf`=0; `inn`=16 → `out`=0, `ovf`=1.
- `inn`=0 with any `inx` (incl. 0) → `out`=1, `ovf`=0, `done` after E0+1. `inx`=0, `inn`=3 → `out`=0, `ovf`=0.
- Completed 3^5, then start 7^9 and pulse `abort` 10 cycles later → IDLE next cycle, no `done`, `out` stays 243. Next start 7^2 → 49.
- `rst` pulse mid-MUL → all outputs at reset values next cycle. `start` pulses while busy are ignored (result unchanged).
- W=8, NW=4 instance: 5^3 → 125, `ovf`=0; 5^4 → 113 (625 mod 256), `ovf`=1. Latency matches s·9+1.

Source files
------------

// File: rtl/pow_pkg.sv
// rtl/pow_pkg.sv - shared types and default widths for the exponentiation unit
package pow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MUL   = 2'd2
    } pow_state_t;

    localparam int POW_W_DEF  = 16;
    localparam int POW_NW_DEF = 8;

endpackage

// File: rtl/pow_seq_if.sv
// rtl/pow_seq_if.sv - start/ready request and result bundle of pow_seq
interface pow_seq_if import pow_pkg::*; #(
    parameter int W  = POW_W_DEF,
    parameter int NW = POW_NW_DEF
) ();

    logic          start;
    logic          abort;
    logic [W-1:0]  inx;
    logic [NW-1:0] inn;
    logic          ready;
    logic          done;
    logic [W-1:0]  out;
    logic          ovf;

    modport master (
        output start, abort, inx, inn,
        input  ready, done, out, ovf
    );

    modport slave (
        input  start, abort, inx, inn,
        output ready, done, out, ovf
    );

endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - radix-2 shift-add W x W -> 2W multiplier, W cycles per product
module mult_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           go,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           mdone
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;

    // Bit 0 of b is folded in on the launch edge so the remaining W-1 bits
    // finish in time for mdone to coincide with a valid product.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (clr) begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b0;
        end else if (go) begin
            acc_d    = b[0] ? {{W{1'b0}}, a} : '0;
            mcand_d  = {{(W-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CW'(W - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign p     = acc_q;
    assign mdone = busy_q && (cnt_q == '0);

endmodule

// File: rtl/pow_seq.sv
// rtl/pow_seq.sv - sequential square-and-multiply x**n mod 2^W with exact overflow flag
module pow_seq import pow_pkg::*; #(
    parameter int W  = POW_W_DEF,
    parameter int NW = POW_NW_DEF
) (
    input  logic      clk,
    input  logic      rst,
    pow_seq_if.slave  bus
);

    pow_state_t    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  x_q, x_d;
    logic [NW-1:0] n_q, n_d;
    logic          a_big_q, a_big_d;
    logic          x_big_q, x_big_d;
    logic [W-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic           m_go, m_clr;
    logic [W-1:0]   m_a;
    logic [2*W-1:0] m_p;
    logic           m_done;
    logic [W-1:0]   hi, lo;

    assign hi = m_p[2*W-1:W];
    assign lo = m_p[W-1:0];

    mult_seq #(.W(W)) u_mult (
        .clk   (clk),
        .rst   (rst),
        .clr   (m_clr),
        .go    (m_go),
        .a     (m_a),
        .b     (x_q),
        .p     (m_p),
        .mdone (m_done)
    );

    // Big flags track whether the true value of a / x has reached 2^W; since
    // a zero base keeps every product (and hi) zero, they stay exact.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        n_d     = n_q;
        a_big_d = a_big_q;
        x_big_d = x_big_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        m_go    = 1'b0;
        m_clr   = 1'b0;
        m_a     = x_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = W'(1);
                    x_d     = bus.inx;
                    n_d     = bus.inn;
                    a_big_d = 1'b0;
                    x_big_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.abort) begin
                    m_clr   = 1'b1;
                    state_d = IDLE;
                end else if (n_q == '0) begin
                    out_d   = a_q;
                    ovf_d   = a_big_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    m_go    = 1'b1;
                    m_a     = n_q[0] ? a_q : x_q;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (bus.abort) begin
                    m_clr   = 1'b1;
                    state_d = IDLE;
                end else if (m_done) begin
                    if (n_q[0]) begin
                        a_d     = lo;
                        a_big_d = a_big_q | x_big_q | (hi != '0);
                        n_d     = n_q - NW'(1);
                    end else begin
                        x_d     = lo;
                        x_big_d = x_big_q | (hi != '0);
                        n_d     = n_q >> 1;
                    end
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_q     <= '0;
            n_q     <= '0;
            a_big_q <= 1'b0;
            x_big_q <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            n_q     <= n_d;
            a_big_q <= a_big_d;
            x_big_q <= x_big_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_pow_seq.sv
// tb/tb_pow_seq.sv - vector table, corner sequences and random model check of pow_seq
module tb_pow_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pow_seq_if #(.W(16), .NW(8)) b16 ();
    pow_seq_if #(.W(8),  .NW(4)) b8 ();

    pow_seq #(.W(16), .NW(8)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    pow_seq #(.W(8),  .NW(4)) dut8  (.clk(clk), .rst(rst), .bus(b8));

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          sel;
        logic [15:0] x;
        logic [7:0]  n;
        longint      e_out;
        bit          e_ovf;
        int          e_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        return (sel == 0) ? b16.done : b8.done;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? b16.ready : b8.ready;
    endfunction

    // Reference: truncated power by repeated modular multiply, overflow from a
    // saturating running product, step count from the halving/decrement rule.
    task automatic model(input int w, input longint x, input int n,
                         output longint o, output bit ov, output int s);
        longint lim = 64'd1 << w;
        longint m = 1;
        longint t = 1;
        int nn = n;
        for (int i = 0; i < n; i++) begin
            m = (m * x) % lim;
            t = t * x;
            if (t > lim) t = lim;
        end
        o  = m;
        ov = (t >= lim);
        s  = 0;
        while (nn != 0) begin
            if (nn % 2 == 1) nn = nn - 1;
            else             nn = nn / 2;
            s++;
        end
    endtask

    task automatic run_op(input int sel, input logic [15:0] x, input logic [7:0] n,
                          input bit poke, output longint o, output bit ov,
                          output int lat, output bit got, output bit rdy_bad,
                          output bit done_long);
        int k = 0;
        got = 0; lat = 0; rdy_bad = 0; done_long = 0; o = 0; ov = 0;
        @(negedge clk);
        if (sel == 0) begin b16.inx = x;      b16.inn = n;      b16.start = 1'b1; end
        else          begin b8.inx  = x[7:0]; b8.inn  = n[3:0]; b8.start  = 1'b1; end
        @(posedge clk); #1;
        b16.start = 1'b0; b8.start = 1'b0;
        while (!got && k < 3000) begin
            if (poke && k == 4) begin
                b16.start = 1'b1; b16.inx = 16'd5; b16.inn = 8'd2;
                b8.start  = 1'b1; b8.inx  = 8'd3;  b8.inn  = 4'd2;
            end
            @(posedge clk); #1;
            b16.start = 1'b0; b8.start = 1'b0;
            k++;
            if (done_of(sel)) begin
                got = 1; lat = k;
                o  = (sel == 0) ? longint'(b16.out) : longint'(b8.out);
                ov = (sel == 0) ? b16.ovf : b8.ovf;
                if (!ready_of(sel)) rdy_bad = 1;
            end else if (ready_of(sel)) begin
                rdy_bad = 1;
            end
        end
        if (got) begin
            @(posedge clk); #1;
            if (done_of(sel)) done_long = 1;
        end
    endtask

    task automatic apply(input string tag, input int sel, input logic [15:0] x,
                         input logic [7:0] n, input bit poke, input longint e_out,
                         input bit e_ovf, input int e_lat);
        longint o; bit ov; int lat; bit got, rb, dl;
        run_op(sel, x, n, poke, o, ov, lat, got, rb, dl);
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            chk({tag, "_out"}, o, e_out);
            chk({tag, "_ovf"}, ov, e_ovf);
            chk({tag, "_latency"}, lat, e_lat);
            chk({tag, "_ready_low_while_busy"}, rb, 0);
            chk({tag, "_done_one_cycle"}, dl, 0);
        end
    endtask

    initial begin
        longint eo; bit ev; int s; int dcount;
        logic [15:0] rx; logic [7:0] rn; int sel, w;

        vecs[0]  = '{0, 16'd3, 8'd5,  243,   1'b0, 69};
        vecs[1]  = '{0, 16'd3, 8'd11, 46075, 1'b1, 103};
        vecs[2]  = '{0, 16'd2, 8'd15, 32768, 1'b0, 120};
        vecs[3]  = '{0, 16'd2, 8'd16, 0,     1'b1, 86};
        vecs[4]  = '{0, 16'd0, 8'd0,  1,     1'b0, 1};
        vecs[5]  = '{0, 16'd9, 8'd0,  1,     1'b0, 1};
        vecs[6]  = '{0, 16'd0, 8'd3,  0,     1'b0, 52};
        vecs[7]  = '{1, 16'd5, 8'd3,  125,   1'b0, 28};
        vecs[8]  = '{1, 16'd5, 8'd4,  113,   1'b1, 28};
        vecs[9]  = '{1, 16'd0, 8'd0,  1,     1'b0, 1};
        vecs[10] = '{0, 16'd65535, 8'd1, 65535, 1'b0, 18};

        b16.start = 0; b16.abort = 0; b16.inx = 0; b16.inn = 0;
        b8.start  = 0; b8.abort  = 0; b8.inx  = 0; b8.inn  = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", b16.ready, 1);
        chk("reset_done",  b16.done,  0);
        chk("reset_out",   b16.out,   0);
        chk("reset_ovf",   b16.ovf,   0);
        chk("reset_ready8", b8.ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            apply($sformatf("vec%0d", i), vecs[i].sel, vecs[i].x, vecs[i].n, 1'b0,
                  vecs[i].e_out, vecs[i].e_ovf, vecs[i].e_lat);

        // busy-time start pulses must not disturb the running operation
        apply("poke16", 0, 16'd3, 8'd5, 1'b1, 243, 1'b0, 69);
        apply("poke8",  1, 16'd5, 8'd3, 1'b1, 125, 1'b0, 28);

        // abort of 7^9 ten cycles after start
        @(negedge clk);
        b16.inx = 16'd7; b16.inn = 8'd9; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        b16.abort = 1'b1;
        @(posedge clk); #1;
        b16.abort = 1'b0;
        chk("abort_ready", b16.ready, 1);
        chk("abort_done",  b16.done,  0);
        dcount = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (b16.done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_out_held", b16.out, 243);
        apply("after_abort", 0, 16'd7, 8'd2, 1'b0, 49, 1'b0, 35);

        // reset in the middle of a multiply
        @(negedge clk);
        b16.inx = 16'd7; b16.inn = 8'd9; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("pre_rst_busy", b16.ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", b16.ready, 1);
        chk("midrst_done",  b16.done,  0);
        chk("midrst_out",   b16.out,   0);
        chk("midrst_ovf",   b16.ovf,   0);
        chk("midrst_out8",  b8.out,    0);

        // randomized operands against the reference model
        for (int i = 0; i < 24; i++) begin
            sel = i % 2;
            w   = (sel == 0) ? 16 : 8;
            rx  = 16'($urandom_range(0, (1 << w) - 1));
            if (i % 3 == 0) rx = 16'($urandom_range(0, 5));
            rn  = (sel == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            if (i % 4 == 1) rn = 8'($urandom_range(0, 3));
            model(w, longint'(rx), int'(rn), eo, ev, s);
            apply($sformatf("rnd%0d_%0d^%0d", i, rx, rn), sel, rx, rn, 1'b0,
                  eo, ev, s * (w + 1) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
